// File: rtl/rv32i_types.sv
// Shared RV32I types for the core pipeline.
// Also holds the branch-resolve FSM state type.
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic {
      BR_IDLE,
      BR_REDIRECT
   } br_state_t;

endpackage

// File: rtl/br_target_calc.sv
// Combinational direction, target and mispredict
// evaluation for an EX-stage control-flow op.
module br_target_calc
   import rv32i_types::*;
(
   input  rv32i_opcode opcode,
   input  rv32i_word   pc,
   input  rv32i_word   imm,
   input  rv32i_word   rs1,
   input  logic        br_en,
   input  logic        pred_taken,
   input  rv32i_word   pred_target,
   output logic        resolvable,
   output logic        is_br,
   output logic        taken,
   output rv32i_word   target,
   output rv32i_word   next_pc,
   output logic        mispredict
);

   // Decode opcode into direction and raw target.
   always_comb begin
      resolvable = 1'b0;
      is_br      = 1'b0;
      taken      = 1'b0;
      target     = pc + imm;
      unique case (opcode)
         op_br: begin
            resolvable = 1'b1;
            is_br      = 1'b1;
            taken      = br_en;
         end
         op_jal: begin
            resolvable = 1'b1;
            taken      = 1'b1;
         end
         op_jalr: begin
            resolvable = 1'b1;
            taken      = 1'b1;
            target     = (rs1 + imm) & ~32'h1;
         end
         default: begin
            resolvable = 1'b0;
         end
      endcase
   end

   // Correct next PC and comparison against the prediction.
   always_comb begin
      next_pc    = taken ? target : pc + 32'd4;
      mispredict = (taken != pred_taken) |
                   (taken & pred_taken & (target != pred_target));
   end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: redirect FSM,
// BHT training pulse and statistics counters.
module branch_resolve
   import rv32i_types::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ex_valid,
   input  logic                 ex_stall,
   input  rv32i_opcode          ex_opcode,
   input  rv32i_word            ex_pc,
   input  rv32i_word            ex_imm,
   input  rv32i_word            ex_rs1,
   input  logic                 br_en,
   input  logic                 pred_taken,
   input  rv32i_word            pred_target,
   input  logic                 redirect_ready,
   output logic                 redirect_valid,
   output rv32i_word            redirect_pc,
   output logic                 flush,
   output logic                 bht_upd_valid,
   output rv32i_word            bht_upd_pc,
   output logic                 bht_upd_taken,
   output logic [CNT_WIDTH-1:0] branch_count,
   output logic [CNT_WIDTH-1:0] mispredict_count
);

   br_state_t state, state_n;

   logic      resolvable;
   logic      is_br;
   logic      taken;
   rv32i_word target;
   rv32i_word next_pc;
   logic      mispredict;
   logic      take;

   br_target_calc u_calc (
      .opcode      (ex_opcode),
      .pc          (ex_pc),
      .imm         (ex_imm),
      .rs1         (ex_rs1),
      .br_en       (br_en),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .resolvable  (resolvable),
      .is_br       (is_br),
      .taken       (taken),
      .target      (target),
      .next_pc     (next_pc),
      .mispredict  (mispredict)
   );

   // Only IDLE accepts work; anything firing while a
   // redirect is outstanding is wrong-path.
   assign take = ex_valid & ~ex_stall & resolvable &
                 (state == BR_IDLE);

   assign redirect_valid = (state == BR_REDIRECT);
   assign flush          = (state == BR_REDIRECT);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= BR_IDLE;
      else     state <= state_n;
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      unique case (state)
         BR_IDLE: begin
            if (take & mispredict) state_n = BR_REDIRECT;
         end
         BR_REDIRECT: begin
            if (redirect_ready) state_n = BR_IDLE;
         end
         default: state_n = BR_IDLE;
      endcase
   end

   // Redirect target, BHT training and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_pc      <= '0;
         bht_upd_valid    <= 1'b0;
         bht_upd_pc       <= '0;
         bht_upd_taken    <= 1'b0;
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         bht_upd_valid <= take & is_br;
         if (take & is_br) begin
            bht_upd_pc    <= ex_pc;
            bht_upd_taken <= taken;
         end
         if (take) begin
            branch_count <= branch_count + 1'b1;
         end
         if (take & mispredict) begin
            mispredict_count <= mispredict_count + 1'b1;
            redirect_pc      <= next_pc;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve.sv
// Randomized + directed bench for branch_resolve,
// checked every cycle against a behavioural model.
module tb_branch_resolve;
   import rv32i_types::*;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_valid;
   logic          ex_stall;
   rv32i_opcode   ex_opcode;
   rv32i_word     ex_pc;
   rv32i_word     ex_imm;
   rv32i_word     ex_rs1;
   logic          br_en;
   logic          pred_taken;
   rv32i_word     pred_target;
   logic          redirect_ready;
   logic          redirect_valid;
   rv32i_word     redirect_pc;
   logic          flush;
   logic          bht_upd_valid;
   rv32i_word     bht_upd_pc;
   logic          bht_upd_taken;
   logic [CW-1:0] branch_count;
   logic [CW-1:0] mispredict_count;

   int errors = 0;
   int checks = 0;

   branch_resolve #(.CNT_WIDTH(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .ex_valid         (ex_valid),
      .ex_stall         (ex_stall),
      .ex_opcode        (ex_opcode),
      .ex_pc            (ex_pc),
      .ex_imm           (ex_imm),
      .ex_rs1           (ex_rs1),
      .br_en            (br_en),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .redirect_ready   (redirect_ready),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .flush            (flush),
      .bht_upd_valid    (bht_upd_valid),
      .bht_upd_pc       (bht_upd_pc),
      .bht_upd_taken    (bht_upd_taken),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_target(
      rv32i_opcode op, logic [31:0] pc,
      logic [31:0] imm, logic [31:0] rs1);
      if (op == op_jalr) return (rs1 + imm) & 32'hFFFF_FFFE;
      return pc + imm;
   endfunction

   // Reference model state: what the outputs must show next.
   logic          m_rv;
   logic [31:0]   m_rpc;
   logic          m_bv;
   logic [31:0]   m_bpc;
   logic          m_bt;
   logic [CW-1:0] m_bc;
   logic [CW-1:0] m_mc;

   always @(posedge clk) begin
      if (rst) begin
         m_rv  <= 1'b0;
         m_rpc <= '0;
         m_bv  <= 1'b0;
         m_bpc <= '0;
         m_bt  <= 1'b0;
         m_bc  <= '0;
         m_mc  <= '0;
      end else begin
         m_bv <= 1'b0;
         if (m_rv) begin
            if (redirect_ready) m_rv <= 1'b0;
         end else if (ex_valid && !ex_stall &&
                      (ex_opcode == op_br || ex_opcode == op_jal ||
                       ex_opcode == op_jalr)) begin
            logic        tk;
            logic [31:0] tg;
            logic        mis;
            tk  = (ex_opcode == op_br) ? br_en : 1'b1;
            tg  = ref_target(ex_opcode, ex_pc, ex_imm, ex_rs1);
            mis = (tk != pred_taken) ||
                  (tk && pred_taken && tg != pred_target);
            m_bc <= m_bc + 1'b1;
            if (ex_opcode == op_br) begin
               m_bv  <= 1'b1;
               m_bpc <= ex_pc;
               m_bt  <= tk;
            end
            if (mis) begin
               m_mc  <= m_mc + 1'b1;
               m_rv  <= 1'b1;
               m_rpc <= tk ? tg : ex_pc + 32'd4;
            end
         end
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      chk("m_redirect_valid", 32'(redirect_valid), 32'(m_rv));
      chk("m_flush", 32'(flush), 32'(m_rv));
      if (m_rv) chk("m_redirect_pc", redirect_pc, m_rpc);
      chk("m_bht_valid", 32'(bht_upd_valid), 32'(m_bv));
      if (m_bv) begin
         chk("m_bht_pc", bht_upd_pc, m_bpc);
         chk("m_bht_taken", 32'(bht_upd_taken), 32'(m_bt));
      end
      chk("m_branch_count", 32'(branch_count), 32'(m_bc));
      chk("m_mispredict_count", 32'(mispredict_count), 32'(m_mc));
   end

   task automatic nclk();
      @(negedge clk);
   endtask

   task automatic issue(rv32i_opcode op, logic [31:0] pc,
                        logic [31:0] imm, logic [31:0] rs1,
                        logic be, logic pt, logic [31:0] ptg);
      ex_valid    = 1'b1;
      ex_stall    = 1'b0;
      ex_opcode   = op;
      ex_pc       = pc;
      ex_imm      = imm;
      ex_rs1      = rs1;
      br_en       = be;
      pred_taken  = pt;
      pred_target = ptg;
   endtask

   task automatic idle();
      ex_valid = 1'b0;
      ex_stall = 1'b0;
   endtask

   task automatic handshake();
      redirect_ready = 1'b1;
      nclk();
      redirect_ready = 1'b0;
   endtask

   rv32i_opcode ops [5] = '{op_br, op_jal, op_jalr, op_reg, op_load};

   initial begin
      rst = 1'b1;
      idle();
      ex_opcode      = op_reg;
      ex_pc          = '0;
      ex_imm         = '0;
      ex_rs1         = '0;
      br_en          = 1'b0;
      pred_taken     = 1'b0;
      pred_target    = '0;
      redirect_ready = 1'b0;
      nclk();
      nclk();
      chk("rst_rv", 32'(redirect_valid), 0);
      chk("rst_rpc", redirect_pc, 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_bc", 32'(branch_count), 0);
      rst = 1'b0;

      // 1: taken beq predicted not-taken
      issue(op_br, 32'h100, 32'h20, 0, 1, 0, 0);
      nclk(); idle();
      chk("t1_rv", 32'(redirect_valid), 1);
      chk("t1_rpc", redirect_pc, 32'h120);
      chk("t1_flush", 32'(flush), 1);
      chk("t1_bv", 32'(bht_upd_valid), 1);
      chk("t1_bpc", bht_upd_pc, 32'h100);
      chk("t1_bt", 32'(bht_upd_taken), 1);
      chk("t1_mc", 32'(mispredict_count), 1);
      handshake();
      chk("t1_idle", 32'(redirect_valid), 0);

      // 2: not-taken bne predicted not-taken
      issue(op_br, 32'h200, 32'h40, 0, 0, 0, 0);
      nclk(); idle();
      chk("t2_rv", 32'(redirect_valid), 0);
      chk("t2_bv", 32'(bht_upd_valid), 1);
      chk("t2_bt", 32'(bht_upd_taken), 0);
      chk("t2_bc", 32'(branch_count), 2);
      chk("t2_mc", 32'(mispredict_count), 1);
      nclk();
      chk("t2_bv_pulse", 32'(bht_upd_valid), 0);

      // 3: jalr wrong target, then right target
      issue(op_jalr, 32'h50, 32'h4, 32'h1003, 0, 1, 32'h1000);
      nclk(); idle();
      chk("t3_rpc", redirect_pc, 32'h1006);
      chk("t3_rv", 32'(redirect_valid), 1);
      chk("t3_bv", 32'(bht_upd_valid), 0);
      handshake();
      issue(op_jalr, 32'h50, 32'h4, 32'h1003, 0, 1, 32'h1006);
      nclk(); idle();
      chk("t3b_rv", 32'(redirect_valid), 0);
      chk("t3b_bc", 32'(branch_count), 4);
      chk("t3b_mc", 32'(mispredict_count), 2);

      // 4: redirect held 5 cycles with wrong-path fires
      issue(op_jal, 32'h300, 32'h40, 0, 0, 0, 0);
      nclk();
      issue(op_br, 32'h700, 32'h8, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         chk("t4_rv", 32'(redirect_valid), 1);
         chk("t4_flush", 32'(flush), 1);
         chk("t4_rpc", redirect_pc, 32'h340);
         chk("t4_bc", 32'(branch_count), 5);
         chk("t4_mc", 32'(mispredict_count), 3);
         nclk();
      end
      redirect_ready = 1'b1;
      nclk();
      redirect_ready = 1'b0;
      idle();
      chk("t4_idle", 32'(redirect_valid), 0);
      chk("t4_bc_after", 32'(branch_count), 5);
      chk("t4_bv_after", 32'(bht_upd_valid), 0);

      // 5: stalled instruction counted once
      issue(op_br, 32'h400, 32'h10, 0, 0, 0, 0);
      ex_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         nclk();
         chk("t5_stall_bv", 32'(bht_upd_valid), 0);
      end
      ex_stall = 1'b0;
      nclk(); idle();
      chk("t5_bv", 32'(bht_upd_valid), 1);
      chk("t5_bc", 32'(branch_count), 6);
      nclk();
      chk("t5_bv_once", 32'(bht_upd_valid), 0);
      chk("t5_bc_once", 32'(branch_count), 6);

      // 5b: drive both counters to all-ones, then wrap
      for (int i = 0; i < 13; i++) begin
         issue(op_br, 32'h800, 32'h10, 0, 0, 0, 0);
         nclk();
      end
      idle();
      for (int i = 0; i < 12; i++) begin
         issue(op_jal, 32'h900, 32'h20, 0, 0, 0, 0);
         nclk(); idle();
         handshake();
      end
      chk("t5_bc_ones", 32'(branch_count), 15);
      chk("t5_mc_ones", 32'(mispredict_count), 15);
      issue(op_jal, 32'h900, 32'h20, 0, 0, 0, 0);
      nclk(); idle();
      chk("t5_bc_wrap", 32'(branch_count), 0);
      chk("t5_mc_wrap", 32'(mispredict_count), 0);
      handshake();

      // 6: reset during REDIRECT, reset beats a fire
      issue(op_br, 32'hA00, 32'h80, 0, 1, 0, 0);
      nclk(); idle();
      chk("t6_pre_rv", 32'(redirect_valid), 1);
      rst = 1'b1;
      nclk();
      chk("t6_rv", 32'(redirect_valid), 0);
      chk("t6_flush", 32'(flush), 0);
      chk("t6_rpc", redirect_pc, 0);
      chk("t6_bc", 32'(branch_count), 0);
      chk("t6_mc", 32'(mispredict_count), 0);
      chk("t6_bv", 32'(bht_upd_valid), 0);
      issue(op_br, 32'hB00, 32'h80, 0, 1, 0, 0);
      nclk();
      rst = 1'b0;
      idle();
      chk("t6_fire_bc", 32'(branch_count), 0);
      chk("t6_fire_rv", 32'(redirect_valid), 0);

      // Random phase
      for (int i = 0; i < 3000; i++) begin
         rv32i_opcode op;
         logic [31:0] pc, imm, rs1;
         op  = ops[$urandom_range(0, 4)];
         pc  = $urandom & 32'hFFFF_FFFC;
         imm = ($urandom_range(0, 1) != 0) ? $urandom
                                           : 32'($urandom_range(0, 64));
         rs1 = $urandom;
         issue(op, pc, imm, rs1, 1'($urandom), 1'($urandom),
               ($urandom_range(0, 1) != 0) ?
                  ref_target(op, pc, imm, rs1) : $urandom);
         ex_valid       = ($urandom_range(0, 3) != 0);
         ex_stall       = ($urandom_range(0, 3) == 0);
         redirect_ready = ($urandom_range(0, 2) == 0);
         rst            = ($urandom_range(0, 199) == 0);
         nclk();
      end
      rst = 1'b0;
      idle();
      nclk();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
